// File: rtl/fm_buffer_reader_pkg.sv
// fm_buffer_reader_pkg
// Definitions shared by the feature-map reader, the writer controller and the
// read-port mux instances.
//   - Default geometry (words per RAM, kernel count) and pipeline latencies.
//   - The reader FSM state type.
package fm_buffer_reader_pkg;

    localparam int unsigned DefaultFmDepth    = 64;
    localparam int unsigned DefaultNumKernels = 8;
    localparam int unsigned DefaultRdLatency  = 2;
    localparam int unsigned DefaultAccLatency = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StWaitLow
    } rd_state_e;

endpackage

// File: rtl/fm_buffer_reader_tag_delay.sv
// tag_delay
// Fixed-depth shift register with synchronous active-low clear. It keeps
// sideband tags in step with a pipelined datapath.
// Ports:
//   clock   in            rising-edge clock
//   clear_n in            synchronous clear, active low; empties every stage
//   din     in  [WIDTH]   value entering the first stage
//   dout    out [WIDTH]   value leaving the last stage, DEPTH cycles after din
module tag_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clock) begin
            if (!clear_n) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= din;
            end
        end
    end else begin : g_chain
        always_ff @(posedge clock) begin
            if (!clear_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= {stage_q[DEPTH-2:0], din};
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fm_buffer_reader.sv
// fm_buffer_reader
// Read-side controller for the feature-map RAMs and weight ROMs. Once the
// writer reports a full buffer, it sweeps every address of every per-kernel
// RAM. The address is the inner loop and the select is the outer loop. The
// words come out as a valid/first/last tagged stream aligned to the mux
// outputs. The buffer goes back to the writer with the final word. The sums
// are flagged ready ACC_LATENCY cycles later.
// Ports:
//   clock          in           rising-edge clock
//   reset          in           synchronous reset, active low
//   buffer_full    in           writer holds a complete map (level)
//   rd_addr        out [ADDR_W] shared RAM/ROM read address
//   ram_select     out [SEL_W]  read-port mux select
//   data_valid     out          mux outputs carry a word of the current pass
//   data_first     out          first word of a pass (clear accumulators)
//   data_last      out          final word of a pass
//   buffer_release out          one-cycle pulse, buffer returned to the writer
//   product_rdy    out          one-cycle pulse, neuron sums settled
//   busy           out          FSM is not idle
module fm_buffer_reader
    import fm_buffer_reader_pkg::*;
#(
    parameter int unsigned NUM_KERNELS = DefaultNumKernels,
    parameter int unsigned FM_DEPTH    = DefaultFmDepth,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned RD_LATENCY  = DefaultRdLatency,
    parameter int unsigned ACC_LATENCY = DefaultAccLatency
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              buffer_full,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              data_valid,
    output logic              data_first,
    output logic              data_last,
    output logic              buffer_release,
    output logic              product_rdy,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(FM_DEPTH - 1);
    localparam logic [SEL_W-1:0]  SelMax  = SEL_W'(NUM_KERNELS - 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q;

    logic              addr_at_end;
    logic              last_issue;
    logic [2:0]        tag_in;   // {last, first, valid} at issue time
    logic [2:0]        tag_out;  // same tags, aligned to the mux outputs

    // Explicit compares keep the wrap exact for non-power-of-2 depths.
    assign addr_at_end = (addr_q == AddrMax);
    assign last_issue  = addr_at_end && (sel_q == SelMax);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        case (state_q)
            StIdle: begin
                if (buffer_full) begin
                    state_d = StRead;
                    addr_d  = '0;
                    sel_d   = '0;
                end
            end
            StRead: begin
                if (last_issue) begin
                    // Counters hold on the final word until the next pass.
                    state_d = StDrain;
                end else if (addr_at_end) begin
                    addr_d = '0;
                    sel_d  = sel_q + SEL_W'(1);
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (data_last) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                // Don't restart on a full flag left over from the pass just finished.
                if (!buffer_full) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    // Every READ cycle issues exactly one word.
    always_comb begin
        tag_in    = '0;
        tag_in[0] = (state_q == StRead);
        tag_in[1] = (state_q == StRead) && (addr_q == '0) && (sel_q == '0);
        tag_in[2] = (state_q == StRead) && last_issue;
    end

    tag_delay #(
        .WIDTH(3),
        .DEPTH(RD_LATENCY)
    ) u_tag_delay (
        .clock  (clock),
        .clear_n(reset),
        .din    (tag_in),
        .dout   (tag_out)
    );

    // Independent of the FSM, so the pulse still fires after a return to IDLE.
    tag_delay #(
        .WIDTH(1),
        .DEPTH(ACC_LATENCY)
    ) u_prod_delay (
        .clock  (clock),
        .clear_n(reset),
        .din    (tag_out[2]),
        .dout   (product_rdy)
    );

    assign rd_addr        = addr_q;
    assign ram_select     = sel_q;
    assign data_valid     = tag_out[0];
    assign data_first     = tag_out[1];
    assign data_last      = tag_out[2];
    assign buffer_release = tag_out[2];
    assign busy           = busy_q;

endmodule

// File: tb/tb_fm_buffer_reader.sv
// Testbench for fm_buffer_reader. Two instances share their inputs: one with
// FM_DEPTH=4 and one with FM_DEPTH=3, both with NUM_KERNELS=2. Each cycle their
// outputs are compared against a timestamp-based reference model.
module tb_fm_buffer_reader;

    localparam int K   = 2;
    localparam int RD  = 2;
    localparam int ACC = 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic buffer_full = 1'b0;

    always #5 clock = ~clock;

    logic [1:0] a_addr, b_addr;
    logic       a_sel, a_valid, a_first, a_last, a_rel, a_prdy, a_busy;
    logic       b_sel, b_valid, b_first, b_last, b_rel, b_prdy, b_busy;

    fm_buffer_reader #(
        .NUM_KERNELS(2), .FM_DEPTH(4), .ADDR_W(2), .SEL_W(1),
        .RD_LATENCY(2), .ACC_LATENCY(1)
    ) dut (
        .clock(clock), .reset(reset), .buffer_full(buffer_full),
        .rd_addr(a_addr), .ram_select(a_sel), .data_valid(a_valid),
        .data_first(a_first), .data_last(a_last), .buffer_release(a_rel),
        .product_rdy(a_prdy), .busy(a_busy)
    );

    fm_buffer_reader #(
        .NUM_KERNELS(2), .FM_DEPTH(3), .ADDR_W(2), .SEL_W(1),
        .RD_LATENCY(2), .ACC_LATENCY(1)
    ) dut3 (
        .clock(clock), .reset(reset), .buffer_full(buffer_full),
        .rd_addr(b_addr), .ram_select(b_sel), .data_valid(b_valid),
        .data_first(b_first), .data_last(b_last), .buffer_release(b_rel),
        .product_rdy(b_prdy), .busy(b_busy)
    );

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;
    bit checking  = 1'b0;

    // Model: age = cycles since entering READ (-1 when no pass is running),
    // low = waiting for buffer_full to drop, prod = cycle product_rdy is due.
    int m_age[2]  = '{-1, -1};
    int m_low[2]  = '{0, 0};
    int m_prod[2] = '{-1, -1};
    int m_addr[2] = '{0, 0};
    int m_sel[2]  = '{0, 0};

    int first_cyc, last_cyc, prdy_cyc, rel_cnt, prdy_cnt;
    int valid_cnt[2];

    function automatic int depth(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_inst(input int i, input logic [31:0] addr, input logic [31:0] sel,
                              input logic [31:0] valid, input logic [31:0] first,
                              input logic [31:0] last, input logic [31:0] rel,
                              input logic [31:0] prdy, input logic [31:0] bsy);
        int a;
        int n;
        a = m_age[i];
        n = depth(i) * K;
        chk($sformatf("u%0d.rd_addr@%0d", i, cyc), addr, m_addr[i]);
        chk($sformatf("u%0d.ram_select@%0d", i, cyc), sel, m_sel[i]);
        chk($sformatf("u%0d.data_valid@%0d", i, cyc), valid, (a >= RD && a <= n - 1 + RD));
        chk($sformatf("u%0d.data_first@%0d", i, cyc), first, (a == RD));
        chk($sformatf("u%0d.data_last@%0d", i, cyc), last, (a == n - 1 + RD));
        chk($sformatf("u%0d.buffer_release@%0d", i, cyc), rel, (a == n - 1 + RD));
        chk($sformatf("u%0d.product_rdy@%0d", i, cyc), prdy, (m_prod[i] == cyc));
        chk($sformatf("u%0d.busy@%0d", i, cyc), bsy, (a >= 0 || m_low[i] != 0));
    endtask

    // Advance the model across the clock edge that samples (r, f).
    task automatic model_step(input logic r, input logic f);
        int a;
        int n;
        for (int i = 0; i < 2; i++) begin
            a = m_age[i];
            n = depth(i) * K;
            if (!r) begin
                m_age[i]  = -1;
                m_low[i]  = 0;
                m_prod[i] = -1;
                m_addr[i] = 0;
                m_sel[i]  = 0;
            end else begin
                if (a == n - 1 + RD) m_prod[i] = cyc + ACC;
                if (a >= 0) begin
                    if (a == n - 1 + RD) begin
                        m_age[i] = -1;
                        m_low[i] = 1;
                    end else begin
                        m_age[i] = a + 1;
                    end
                end else if (m_low[i] != 0) begin
                    if (!f) m_low[i] = 0;
                end else if (f) begin
                    m_age[i] = 0;
                end
                if (m_age[i] >= 0 && m_age[i] < n) begin
                    m_addr[i] = m_age[i] % depth(i);
                    m_sel[i]  = m_age[i] / depth(i);
                end
            end
        end
    endtask

    // One cycle: check outputs of the current cycle, then drive its inputs.
    task automatic step(input logic r, input logic f);
        @(negedge clock);
        if (checking) begin
            check_inst(0, a_addr, a_sel, a_valid, a_first, a_last, a_rel, a_prdy, a_busy);
            check_inst(1, b_addr, b_sel, b_valid, b_first, b_last, b_rel, b_prdy, b_busy);
            if (a_first) first_cyc = cyc;
            if (a_last) last_cyc = cyc;
            if (a_prdy) begin
                prdy_cyc = cyc;
                prdy_cnt++;
            end
            if (a_rel) rel_cnt++;
            if (a_valid) valid_cnt[0]++;
            if (b_valid) valid_cnt[1]++;
        end
        reset       = r;
        buffer_full = f;
        model_step(r, f);
        cyc++;
        checking = 1'b1;
    endtask

    task automatic clear_monitors();
        first_cyc    = -1;
        last_cyc     = -1;
        prdy_cyc     = -1;
        rel_cnt      = 0;
        prdy_cnt     = 0;
        valid_cnt[0] = 0;
        valid_cnt[1] = 0;
    endtask

    initial begin
        int  t0;
        logic f;

        clear_monitors();

        // Power-on: reset held low with buffer_full high; outputs stay 0.
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        @(posedge clock);
        #1;
        chk("poweron_read_entered", a_busy, 1);
        chk("poweron_addr_zero", a_addr, 0);

        // Stale full: held high well past the release; no second pass.
        repeat (16) step(1'b1, 1'b1);
        @(posedge clock);
        #1;
        chk("stale_busy_waitlow", a_busy, 1);
        chk("stale_no_restart", a_valid, 0);
        repeat (3) step(1'b1, 1'b0);

        // Basic pass with absolute timing, plus word counts for both depths.
        clear_monitors();
        t0 = cyc;
        repeat (14) step(1'b1, 1'b1);
        chk("basic_first_offset", first_cyc - t0, 3);
        chk("basic_last_offset", last_cyc - t0, 10);
        chk("basic_prdy_offset", prdy_cyc - t0, 11);
        chk("basic_valid_words", valid_cnt[0], 8);
        chk("depth3_valid_words", valid_cnt[1], 6);
        repeat (3) step(1'b1, 1'b0);

        // Mid-pass reset: aborted pass produces no release or product pulse.
        step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b1);
        clear_monitors();
        step(1'b0, 1'b1);
        @(posedge clock);
        #1;
        chk("abort_busy", a_busy, 0);
        chk("abort_valid", a_valid, 0);
        chk("abort_addr", a_addr, 0);
        repeat (15) step(1'b1, 1'b0);
        chk("abort_no_release", rel_cnt, 0);
        chk("abort_no_prdy", prdy_cnt, 0);

        // Glitchy full during READ/DRAIN: timing must match the basic pass.
        clear_monitors();
        t0 = cyc;
        step(1'b1, 1'b1);
        repeat (13) step(1'b1, 1'($urandom_range(0, 1)));
        chk("glitch_first_offset", first_cyc - t0, 3);
        chk("glitch_last_offset", last_cyc - t0, 10);
        chk("glitch_prdy_offset", prdy_cyc - t0, 11);
        chk("glitch_valid_words", valid_cnt[0], 8);
        repeat (4) step(1'b1, 1'b0);

        // Random traffic on buffer_full with occasional resets.
        f = 1'b0;
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 7) == 0) f = ~f;
            step(($urandom_range(0, 299) != 0), f);
        end
        step(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
